// File: rtl/sram_like_pkg.sv
// Shared types and constants for the SRAM-like bus responder.
// Random handshake delays are enabled by defining SRAM_LIKE_RAND_DELAY_EN.
package sram_like_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef struct packed {
      logic        wr;
      logic [31:0] data;
   } rsp_entry_t;

endpackage

// File: rtl/sram_like_if.sv
// SRAM-like bus: request/address phase (req/addr_ok) and in-order response phase (data_ok).
interface sram_like_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_like_rsp_fifo.sv
// Circular response queue with a saturating per-entry age counter.
// Read data arrives one cycle after push and is bypassed to the head while pending.
module sram_like_rsp_fifo
   import sram_like_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int DATA_DELAY = 1
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic                     push_wr,
   input  logic [31:0]              fill_data,
   input  logic                     pop,
   output logic                     head_ready,
   output rsp_entry_t               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW    = $clog2(DEPTH);
   localparam int AGE_W = $clog2(DATA_DELAY + 1) + 1;
   localparam logic [AGE_W-1:0] AGE_MAX   = '1;
   localparam logic [AGE_W-1:0] AGE_READY = DATA_DELAY[AGE_W-1:0];
   localparam logic [PW:0]      DEPTH_C   = DEPTH[PW:0];

   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [PW-1:0] fill_idx_reg;
   logic          fill_pending_reg;
   logic [PW:0]   count_reg;

   rsp_entry_t       entry_arr [DEPTH];
   logic [AGE_W-1:0] age_arr   [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic             wr_reg;
         logic [31:0]      data_reg;
         logic [AGE_W-1:0] age_reg;

         always_ff @(posedge clk) begin
            if (push && wr_ptr_reg == PW'(gi)) wr_reg <= push_wr;
            if (fill_pending_reg && fill_idx_reg == PW'(gi)) data_reg <= fill_data;
         end

         // Age counts cycles since the handshake, so it reads 1 in the cycle after push.
         always_ff @(posedge clk) begin
            if (!resetn) begin
               age_reg <= '0;
            end else if (push && wr_ptr_reg == PW'(gi)) begin
               age_reg <= AGE_W'(1);
            end else if (age_reg != AGE_MAX) begin
               age_reg <= age_reg + AGE_W'(1);
            end
         end

         assign entry_arr[gi] = '{wr: wr_reg, data: data_reg};
         assign age_arr[gi]   = age_reg;
      end
   endgenerate

   always_comb begin
      head = entry_arr[rd_ptr_reg];
      if (fill_pending_reg && fill_idx_reg == rd_ptr_reg) head.data = fill_data;
   end

   assign empty      = (count_reg == '0);
   assign full       = (count_reg == DEPTH_C);
   assign head_ready = !empty && (age_arr[rd_ptr_reg] >= AGE_READY);
   assign count      = count_reg;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         fill_idx_reg     <= '0;
         fill_pending_reg <= 1'b0;
         count_reg        <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         fill_pending_reg <= push;
         if (push) fill_idx_reg <= wr_ptr_reg;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (PW+1)'(1);
            2'b01:   count_reg <= count_reg - (PW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end
endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like bus responder backed by a word array; writes commit at the address handshake.
// Optional LFSR-driven handshake throttling: define SRAM_LIKE_RAND_DELAY_EN.
module sram_like_slave
   import sram_like_pkg::*;
#(
   parameter int          MEM_AW          = 12,
   parameter int          MAX_OUTSTANDING = 4,
   parameter int          ADDR_DELAY      = 0,
   parameter int          DATA_DELAY      = 1,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                               clk,
   input  logic                               resetn,
   sram_like_if.slave                         bus,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);
   localparam int HOLD_W = $clog2(ADDR_DELAY + 1) + 1;
   localparam logic [HOLD_W-1:0] HOLD_READY = ADDR_DELAY[HOLD_W-1:0];

   logic [31:0]       mem [2**MEM_AW];
   logic [31:0]       ram_q_reg;
   logic [MEM_AW-1:0] word_idx;
   logic [HOLD_W-1:0] hold_reg;
   logic              handshake;
   logic              full;
   logic              empty;
   logic              head_ready;
   rsp_entry_t        head;
   logic              rand_addr_ok;
   logic              rand_data_ok;

`ifdef SRAM_LIKE_RAND_DELAY_EN
   logic [15:0] lfsr_reg;

   always_ff @(posedge clk) begin
      if (!resetn) lfsr_reg <= LFSR_SEED;
      else         lfsr_reg <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
   end

   assign rand_addr_ok = lfsr_reg[0];
   assign rand_data_ok = lfsr_reg[1];
`else
   logic [15:0] unused_seed;
   assign unused_seed  = LFSR_SEED;
   assign rand_addr_ok = 1'b1;
   assign rand_data_ok = 1'b1;
`endif

   // Upper address bits alias onto the array; size and byte offset are not interpreted.
   assign word_idx = bus.addr[MEM_AW+1:2];

   logic unused_bits;
   assign unused_bits = ^{bus.size, bus.addr[31:MEM_AW+2], bus.addr[1:0], empty};

   assign bus.addr_ok = resetn & bus.req & ~full & (hold_reg >= HOLD_READY) & rand_addr_ok;
   assign handshake   = bus.req & bus.addr_ok;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         hold_reg <= '0;
      end else if (!bus.req || handshake) begin
         hold_reg <= '0;
      end else if (hold_reg != '1) begin
         hold_reg <= hold_reg + HOLD_W'(1);
      end
   end

   // Read-first port: a read handshaking right after a write sees the committed word.
   always_ff @(posedge clk) begin
      if (handshake && bus.wr) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.wstrb[i]) mem[word_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
         end
      end
      ram_q_reg <= mem[word_idx];
   end

   sram_like_rsp_fifo #(
      .DEPTH      (MAX_OUTSTANDING),
      .DATA_DELAY (DATA_DELAY)
   ) u_rsp_fifo (
      .clk        (clk),
      .resetn     (resetn),
      .push       (handshake),
      .push_wr    (bus.wr),
      .fill_data  (ram_q_reg),
      .pop        (bus.data_ok),
      .head_ready (head_ready),
      .head       (head),
      .full       (full),
      .empty      (empty),
      .count      (outstanding)
   );

   assign bus.data_ok = resetn & head_ready & rand_data_ok;
   assign bus.rdata   = (bus.data_ok && !head.wr) ? head.data : 32'h0;
endmodule

// File: tb/tb_sram_like_slave.sv
// Directed bench for sram_like_slave: four instances cover the delay/size configurations.
module tb_sram_like_slave;
   import sram_like_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic        req, wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr, wdata;
   int          sel;

   logic        addr_ok_m, data_ok_m;
   logic [31:0] rdata_m;
   logic [2:0]  outst_m;
   logic [2:0]  os_a, os_b, os_c, os_d;

   int n_checks = 0;
   int n_errors = 0;

   sram_like_if bus_a ();
   sram_like_if bus_b ();
   sram_like_if bus_c ();
   sram_like_if bus_d ();

   assign bus_a.req = req && (sel == 0);
   assign bus_b.req = req && (sel == 1);
   assign bus_c.req = req && (sel == 2);
   assign bus_d.req = req && (sel == 3);
   assign bus_a.wr = wr; assign bus_a.size = size; assign bus_a.wstrb = wstrb; assign bus_a.addr = addr; assign bus_a.wdata = wdata;
   assign bus_b.wr = wr; assign bus_b.size = size; assign bus_b.wstrb = wstrb; assign bus_b.addr = addr; assign bus_b.wdata = wdata;
   assign bus_c.wr = wr; assign bus_c.size = size; assign bus_c.wstrb = wstrb; assign bus_c.addr = addr; assign bus_c.wdata = wdata;
   assign bus_d.wr = wr; assign bus_d.size = size; assign bus_d.wstrb = wstrb; assign bus_d.addr = addr; assign bus_d.wdata = wdata;

   sram_like_slave #(.MEM_AW(12), .MAX_OUTSTANDING(4), .ADDR_DELAY(0), .DATA_DELAY(1))
      u_a (.clk(clk), .resetn(resetn), .bus(bus_a), .outstanding(os_a));
   sram_like_slave #(.MEM_AW(12), .MAX_OUTSTANDING(4), .ADDR_DELAY(0), .DATA_DELAY(8))
      u_b (.clk(clk), .resetn(resetn), .bus(bus_b), .outstanding(os_b));
   sram_like_slave #(.MEM_AW(12), .MAX_OUTSTANDING(4), .ADDR_DELAY(0), .DATA_DELAY(2))
      u_c (.clk(clk), .resetn(resetn), .bus(bus_c), .outstanding(os_c));
   sram_like_slave #(.MEM_AW(10), .MAX_OUTSTANDING(4), .ADDR_DELAY(3), .DATA_DELAY(1))
      u_d (.clk(clk), .resetn(resetn), .bus(bus_d), .outstanding(os_d));

   always_comb begin
      case (sel)
         1:       begin addr_ok_m = bus_b.addr_ok; data_ok_m = bus_b.data_ok; rdata_m = bus_b.rdata; outst_m = os_b; end
         2:       begin addr_ok_m = bus_c.addr_ok; data_ok_m = bus_c.data_ok; rdata_m = bus_c.rdata; outst_m = os_c; end
         3:       begin addr_ok_m = bus_d.addr_ok; data_ok_m = bus_d.data_ok; rdata_m = bus_d.rdata; outst_m = os_d; end
         default: begin addr_ok_m = bus_a.addr_ok; data_ok_m = bus_a.data_ok; rdata_m = bus_a.rdata; outst_m = os_a; end
      endcase
   end

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t        vecs [11];
   logic        s_wr   [8];
   logic [31:0] s_addr [8];
   logic [31:0] s_dat  [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // One isolated transaction on an idle instance: handshake, then wait for its response.
   task automatic txn(input int s, input bit w, input logic [31:0] a, input logic [3:0] st,
                      input logic [31:0] d, input logic [31:0] exp_r, input int exp_aw,
                      input int exp_dl, input string nm);
      int aw;
      int dl;
      bit got;
      @(posedge clk); #1;
      sel = s; req = 1'b1; wr = w; addr = a; wstrb = st; wdata = d; size = SZ_WORD;
      aw = 0; got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (addr_ok_m) begin got = 1'b1; break; end
         aw++;
      end
      chk({nm, " addr_ok seen"}, 32'(got), 32'd1);
      chk({nm, " no data_ok in handshake cycle"}, 32'(data_ok_m), 32'd0);
      @(posedge clk); #1;
      req = 1'b0;
      dl = 0; got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         dl++;
         @(negedge clk);
         if (data_ok_m) begin got = 1'b1; break; end
      end
      chk({nm, " data_ok seen"}, 32'(got), 32'd1);
      chk({nm, " rdata"}, rdata_m, exp_r);
      chk({nm, " addr wait"}, 32'(aw), 32'(exp_aw));
      chk({nm, " data latency"}, 32'(dl), 32'(exp_dl));
      $display("txn %-14s inst=%0d %s addr=0x%08h wstrb=%h wdata=0x%08h rdata=0x%08h addr_wait=%0d lat=%0d",
               nm, s, w ? "W" : "R", a, st, d, rdata_m, aw, dl);
   endtask

   // Back-to-back stream of n requests from s_* arrays; responses must arrive in order.
   task automatic stream(input int s, input int n, input int lat, input string nm);
      int issued, recv, c, first_hs, first_rsp, last_rsp;
      bit hs;
      logic [31:0] exp_r;
      issued = 0; recv = 0; c = 0; first_hs = -1; first_rsp = -1; last_rsp = -1;
      @(posedge clk); #1;
      sel = s; req = 1'b1; wr = s_wr[0]; addr = s_addr[0]; wdata = s_dat[0]; wstrb = 4'hF; size = SZ_WORD;
      while (recv < n && c < 200) begin
         @(negedge clk);
         if (data_ok_m) begin
            exp_r = s_wr[recv] ? 32'h0 : s_dat[recv];
            chk($sformatf("%s rsp%0d rdata", nm, recv), rdata_m, exp_r);
            $display("rsp %s #%0d %s rdata=0x%08h expect=0x%08h", nm, recv, s_wr[recv] ? "W" : "R", rdata_m, exp_r);
            if (first_rsp < 0) first_rsp = c;
            last_rsp = c;
            recv++;
         end
         hs = req && addr_ok_m;
         if (hs && first_hs < 0) first_hs = c;
         @(posedge clk); #1;
         if (hs) begin
            issued++;
            if (issued < n) begin
               wr = s_wr[issued]; addr = s_addr[issued]; wdata = s_dat[issued];
            end else begin
               req = 1'b0;
            end
         end
         c++;
      end
      req = 1'b0;
      chk({nm, " responses"}, 32'(recv), 32'(n));
      chk({nm, " first latency"}, 32'(first_rsp - first_hs), 32'(lat));
      chk({nm, " consecutive"}, 32'(last_rsp - first_rsp), 32'(n - 1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs_cnt, first_dok, fifth, cnt;

      vecs[0]  = '{1'b1, 32'h0000_0100, 4'hF,    32'h1122_3344, 32'h0};
      vecs[1]  = '{1'b1, 32'h0000_0100, 4'b0100, 32'h00AA_0000, 32'h0};
      vecs[2]  = '{1'b0, 32'h0000_0100, 4'h0,    32'h0,         32'h11AA_3344};
      vecs[3]  = '{1'b1, 32'h0000_0104, 4'hF,    32'h0,         32'h0};
      vecs[4]  = '{1'b1, 32'h0000_0104, 4'b1001, 32'hAABB_CCDD, 32'h0};
      vecs[5]  = '{1'b0, 32'h0000_0104, 4'h0,    32'h0,         32'hAA00_00DD};
      vecs[6]  = '{1'b1, 32'h0000_0108, 4'hF,    32'h0102_0304, 32'h0};
      vecs[7]  = '{1'b1, 32'h0000_0108, 4'b0010, 32'hFFFF_FFFF, 32'h0};
      vecs[8]  = '{1'b0, 32'h0000_0108, 4'h0,    32'h0,         32'h0102_FF04};
      vecs[9]  = '{1'b0, 32'h0000_0000, 4'h0,    32'h0,         32'hDEAD_BEEF};
      vecs[10] = '{1'b0, 32'h0000_4100, 4'h0,    32'h0,         32'h11AA_3344};

      // Reset with req held: nothing may be accepted or returned.
      sel = 0; req = 1'b1; wr = 1'b0; size = SZ_WORD; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset addr_ok", 32'(addr_ok_m), 32'd0);
      chk("reset data_ok", 32'(data_ok_m), 32'd0);
      chk("reset rdata", rdata_m, 32'h0);
      @(posedge clk); #1;
      req = 1'b0;
      resetn = 1'b1;
      @(negedge clk);
      chk("reset outstanding", 32'(outst_m), 32'd0);
      $display("seq reset: addr_ok/data_ok/rdata/outstanding checked");

      // Write then read the same word on consecutive cycles.
      @(posedge clk); #1;
      sel = 0; req = 1'b1; wr = 1'b1; addr = 32'h1C00_0000; wstrb = 4'hF; wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("raw wr addr_ok", 32'(addr_ok_m), 32'd1);
      chk("raw wr no data_ok", 32'(data_ok_m), 32'd0);
      @(posedge clk); #1;
      wr = 1'b0;
      @(negedge clk);
      chk("raw rd addr_ok", 32'(addr_ok_m), 32'd1);
      chk("raw wr data_ok", 32'(data_ok_m), 32'd1);
      chk("raw wr rdata", rdata_m, 32'h0);
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      chk("raw rd data_ok", 32'(data_ok_m), 32'd1);
      chk("raw rd rdata", rdata_m, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      @(negedge clk);
      chk("raw drained", 32'(outst_m), 32'd0);
      $display("seq raw: W 0x1c000000=0xDEADBEEF then R -> 0x%08h", 32'hDEAD_BEEF);

      for (int i = 0; i < 11; i++)
         txn(0, vecs[i].wr, vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, vecs[i].exp_rdata,
             0, 1, $sformatf("vec%0d", i));

      // Full queue: four accepts, stall until the first response, then accept next cycle.
      hs_cnt = 0; first_dok = -1; fifth = -1;
      @(posedge clk); #1;
      sel = 1; req = 1'b1; wr = 1'b0; addr = 32'h0;
      for (int c = 0; c < 30 && fifth < 0; c++) begin
         @(negedge clk);
         if (c == 4) chk("full outstanding", 32'(outst_m), 32'd4);
         if (c == 8) chk("full no pass-through", 32'(addr_ok_m), 32'd0);
         if (data_ok_m && first_dok < 0) first_dok = c;
         if (addr_ok_m) begin
            hs_cnt++;
            if (hs_cnt == 4) chk("full 4th accept cycle", 32'(c), 32'd3);
            if (hs_cnt == 5) fifth = c;
         end
         @(posedge clk); #1;
         if (hs_cnt == 5) req = 1'b0;
         addr = addr + 32'd4;
      end
      req = 1'b0;
      chk("full first data_ok cycle", 32'(first_dok), 32'd8);
      chk("full 5th accept cycle", 32'(fifth), 32'd9);
      cnt = 0;
      while (outst_m != 3'd0 && cnt < 40) begin @(negedge clk); cnt++; end
      chk("full drained", 32'(outst_m), 32'd0);
      $display("seq full: first data_ok at %0d, 5th accept at %0d", first_dok, fifth);

      // 2 x MAX_OUTSTANDING writes then reads, exercising pointer wrap.
      for (int i = 0; i < 8; i++) begin
         s_wr[i] = 1'b1; s_addr[i] = 32'h2000 + 32'(i) * 4; s_dat[i] = 32'hC0DE_0000 | (32'(i) * 32'h0101_0011);
      end
      stream(2, 8, 2, "wstream");
      for (int i = 0; i < 8; i++) s_wr[i] = 1'b0;
      stream(2, 8, 2, "rstream");

      // Reset with two reads in flight drops them; the earlier write survives.
      txn(2, 1'b1, 32'h300, 4'hF, 32'h0BAD_CAFE, 32'h0, 0, 2, "pre-reset wr");
      @(posedge clk); #1;
      sel = 2; req = 1'b1; wr = 1'b0; addr = 32'h300;
      @(negedge clk);
      chk("inflight rd0 addr_ok", 32'(addr_ok_m), 32'd1);
      @(posedge clk); #1;
      addr = 32'h304;
      @(negedge clk);
      chk("inflight rd1 addr_ok", 32'(addr_ok_m), 32'd1);
      @(posedge clk); #1;
      req = 1'b0; resetn = 1'b0;
      @(negedge clk);
      chk("inflight reset data_ok", 32'(data_ok_m), 32'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (data_ok_m) cnt++;
      end
      chk("post-reset data_ok count", 32'(cnt), 32'd0);
      chk("post-reset outstanding", 32'(outst_m), 32'd0);
      $display("seq mid-op reset: data_ok after reset=%0d", cnt);
      txn(2, 1'b0, 32'h300, 4'h0, 32'h0, 32'h0BAD_CAFE, 0, 2, "post-reset rd");

      // MEM_AW=10 aliasing and ADDR_DELAY=3 accept on the 4th held cycle.
      txn(3, 1'b1, 32'h1000, 4'hF, 32'h1234_5678, 32'h0, 3, 1, "alias wr");
      txn(3, 1'b0, 32'h0000, 4'h0, 32'h0, 32'h1234_5678, 3, 1, "alias rd");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
